// File: rtl/spi_rd_master.sv
// SPI flash-read sequencer (mode 0): CMD, 24-bit ADDR, optional MODE byte, dummy bytes and
// data bytes, each phase in single, dual or quad lane mode. Received bytes stream out MSB first.
module spi_rd_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             sys_clk_i,
    input  logic             reset_ni,
    input  logic             req_i,
    input  logic [7:0]       cmd_i,
    input  logic [23:0]      addr_i,
    input  logic [1:0]       imode_i,
    input  logic [1:0]       fmode_i,
    input  logic             mode_en_i,
    input  logic [3:0]       dummy_n_i,
    input  logic [LEN_W-1:0] rd_len_i,
    output logic             busy_o,
    output logic [7:0]       rdata_o,
    output logic             rdata_vld_o,
    output logic             done_o,
    output logic             spi_sck_o,
    output logic             spi_csn_o,
    output logic [3:0]       spi_sdo_o,
    output logic [3:0]       spi_oen_o,
    input  logic [3:0]       spi_sdi_i
);
    localparam int unsigned CntW    = (LEN_W > 4) ? LEN_W : 4;
    localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        StIdle, StCsSetup, StCmd, StAddr, StMode, StDummy, StData, StCsHold, StCsGap
    } state_e;

    function automatic logic [3:0] lanes_out(input logic [1:0] m, input logic [31:0] w);
        case (m)
            2'b10:   return w[31:28];
            2'b01:   return {2'b00, w[31:30]};
            default: return {3'b000, w[31]};
        endcase
    endfunction

    function automatic logic [31:0] shift_tx(input logic [1:0] m, input logic [31:0] w);
        case (m)
            2'b10:   return w << 4;
            2'b01:   return w << 2;
            default: return w << 1;
        endcase
    endfunction

    function automatic logic [7:0] shift_rx(input logic [1:0] m, input logic [7:0] r,
                                            input logic [3:0] d);
        case (m)
            2'b10:   return {r[3:0], d};
            2'b01:   return {r[5:0], d[1:0]};
            default: return {r[6:0], d[1]};
        endcase
    endfunction

    function automatic logic [3:0] oen_of(input logic [1:0] m);
        case (m)
            2'b10:   return 4'b0000;
            2'b01:   return 4'b1100;
            default: return 4'b1110;
        endcase
    endfunction

    // Index of the last SCK within one byte for the given lane mode.
    function automatic logic [2:0] sck_last(input logic [1:0] m);
        case (m)
            2'b10:   return 3'd1;
            2'b01:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    state_e          state_q;
    logic [7:0]      div_q;
    logic            sck_q, csn_q, busy_q, done_q, vld_q;
    logic [3:0]      sdo_q, oen_q;
    logic [7:0]      rdata_q, rx_q;
    logic [31:0]     tx_q;
    logic [1:0]      mode_q;
    logic [2:0]      bit_q;
    logic [CntW-1:0] byte_q;
    logic [7:0]      cmd_q;
    logic [23:0]     addr_q;
    logic [1:0]      imode_q, fmode_q;
    logic            mode_en_q;
    logic [3:0]      dummy_q;
    logic [LEN_W-1:0] len_q;

    state_e          nxt_st;
    logic [31:0]     ent_word, tx_nxt;
    logic [1:0]      ent_mode;
    logic [CntW-1:0] ent_bytes;
    logic [3:0]      ent_oen;
    logic            has_dummy, has_data, in_phase, enter;

    assign has_dummy = (dummy_q != 4'd0);
    assign has_data  = (len_q != '0);
    assign in_phase  = state_q inside {StCmd, StAddr, StMode, StDummy, StData};
    assign tx_nxt    = shift_tx(mode_q, tx_q);
    // Phase change happens on the SCK fall that ends the last bit of the last byte.
    assign enter = (div_q == DivLast) &&
                   ((state_q == StCsSetup) ||
                    (in_phase && sck_q && bit_q == 3'd0 && byte_q == CntW'(1)));

    always_comb begin
        nxt_st = StCsHold;
        case (state_q)
            StCsSetup: nxt_st = StCmd;
            StCmd:     nxt_st = StAddr;
            StAddr: begin
                if (mode_en_q)      nxt_st = StMode;
                else if (has_dummy) nxt_st = StDummy;
                else if (has_data)  nxt_st = StData;
            end
            StMode: begin
                if (has_dummy)     nxt_st = StDummy;
                else if (has_data) nxt_st = StData;
            end
            StDummy: if (has_data) nxt_st = StData;
            default: nxt_st = StCsHold;
        endcase

        ent_word  = '0;
        ent_mode  = fmode_q;
        ent_bytes = '0;
        ent_oen   = 4'hF;
        case (nxt_st)
            StCmd: begin
                ent_word  = {cmd_q, 24'h0};
                ent_mode  = imode_q;
                ent_bytes = CntW'(1);
                ent_oen   = oen_of(imode_q);
            end
            StAddr: begin
                ent_word  = {addr_q, 8'h0};
                ent_bytes = CntW'(3);
                ent_oen   = oen_of(fmode_q);
            end
            StMode: begin
                ent_bytes = CntW'(1);
                ent_oen   = oen_of(fmode_q);
            end
            StDummy: ent_bytes = CntW'(dummy_q);
            StData:  ent_bytes = CntW'(len_q);
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            div_q     <= '0;
            sck_q     <= 1'b0;
            csn_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
            sdo_q     <= 4'h0;
            oen_q     <= 4'hF;
            rdata_q   <= 8'h00;
            rx_q      <= 8'h00;
            tx_q      <= '0;
            mode_q    <= 2'b00;
            bit_q     <= 3'd0;
            byte_q    <= '0;
            cmd_q     <= 8'h00;
            addr_q    <= 24'h0;
            imode_q   <= 2'b00;
            fmode_q   <= 2'b00;
            mode_en_q <= 1'b0;
            dummy_q   <= 4'd0;
            len_q     <= '0;
        end else begin
            done_q <= 1'b0;
            vld_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        cmd_q     <= cmd_i;
                        addr_q    <= addr_i;
                        imode_q   <= imode_i;
                        fmode_q   <= fmode_i;
                        mode_en_q <= mode_en_i;
                        dummy_q   <= dummy_n_i;
                        len_q     <= rd_len_i;
                        busy_q    <= 1'b1;
                        csn_q     <= 1'b0;
                        div_q     <= '0;
                        state_q   <= StCsSetup;
                    end
                end
                StCsSetup: if (div_q != DivLast) div_q <= div_q + 8'd1;
                StCmd, StAddr, StMode, StDummy, StData: begin
                    if (div_q != DivLast) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q <= '0;
                        sck_q <= ~sck_q;
                        if (!sck_q) begin
                            if (state_q == StData) rx_q <= shift_rx(mode_q, rx_q, spi_sdi_i);
                        end else begin
                            if (state_q == StData && bit_q == 3'd0) begin
                                rdata_q <= rx_q;
                                vld_q   <= 1'b1;
                            end
                            if (bit_q != 3'd0) begin
                                bit_q <= bit_q - 3'd1;
                                tx_q  <= tx_nxt;
                                sdo_q <= lanes_out(mode_q, tx_nxt);
                            end else if (byte_q != CntW'(1)) begin
                                byte_q <= byte_q - CntW'(1);
                                bit_q  <= sck_last(mode_q);
                                tx_q   <= tx_nxt;
                                sdo_q  <= lanes_out(mode_q, tx_nxt);
                            end
                        end
                    end
                end
                StCsHold: begin
                    if (div_q != DivLast) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q   <= '0;
                        csn_q   <= 1'b1;
                        state_q <= StCsGap;
                    end
                end
                StCsGap: begin
                    if (div_q != DivLast) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (enter) begin
                state_q <= nxt_st;
                div_q   <= '0;
                tx_q    <= ent_word;
                sdo_q   <= lanes_out(ent_mode, ent_word);
                oen_q   <= ent_oen;
                mode_q  <= ent_mode;
                byte_q  <= ent_bytes;
                bit_q   <= sck_last(ent_mode);
            end
        end
    end

    assign busy_o      = busy_q;
    assign rdata_o     = rdata_q;
    assign rdata_vld_o = vld_q;
    assign done_o      = done_q;
    assign spi_sck_o   = sck_q;
    assign spi_csn_o   = csn_q;
    assign spi_sdo_o   = sdo_q;
    assign spi_oen_o   = oen_q;
endmodule

// File: tb/tb_spi_rd_master.sv
// Bench for spi_rd_master: flash slave model, timing monitor and an rdata scoreboard.
module tb_spi_rd_master;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [23:0] addr = 24'h0;
    logic [1:0] imode = 2'b00, fmode = 2'b00;
    logic       mode_en = 1'b0;
    logic [3:0] dummy_n = 4'd0;
    logic [7:0] rd_len = 8'd0;
    logic       busy, rdata_vld, done, spi_sck, spi_csn;
    logic [7:0] rdata;
    logic [3:0] spi_sdo, spi_oen, spi_sdi;

    spi_rd_master #(.CLK_DIV(4), .LEN_W(8)) dut (
        .sys_clk_i(clk), .reset_ni(rst_n), .req_i(req), .cmd_i(cmd), .addr_i(addr),
        .imode_i(imode), .fmode_i(fmode), .mode_en_i(mode_en), .dummy_n_i(dummy_n),
        .rd_len_i(rd_len), .busy_o(busy), .rdata_o(rdata), .rdata_vld_o(rdata_vld),
        .done_o(done), .spi_sck_o(spi_sck), .spi_csn_o(spi_csn), .spi_sdo_o(spi_sdo),
        .spi_oen_o(spi_oen), .spi_sdi_i(spi_sdi)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] flash [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int unsigned spb(input logic [1:0] m);
        case (m)
            2'b10:   return 2;
            2'b01:   return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [3:0] exp_oen_of(input logic [1:0] m);
        case (m)
            2'b10:   return 4'b0000;
            2'b01:   return 4'b1100;
            default: return 4'b1110;
        endcase
    endfunction

    // Slave configuration for the current transaction, in SCK rising-edge indices.
    int unsigned s_cmd, s_pre, s_ds, s_dscks;
    logic [1:0]  s_imode, s_fmode;

    function automatic logic [3:0] exp_oen(input int unsigned k);
        if (k < s_cmd) return exp_oen_of(s_imode);
        if (k < s_pre) return exp_oen_of(s_fmode);
        return 4'hF;
    endfunction

    function automatic logic [3:0] slave_bits(input int unsigned k);
        int unsigned g, per, ln, sh;
        logic [7:0] v;
        if (k < s_ds || k >= s_ds + s_dscks) return 4'h0;
        g   = k - s_ds;
        per = spb(s_fmode);
        ln  = 8 / per;
        sh  = 8 - ln * (g % per + 1);
        v   = flash[g / per] >> sh;
        case (ln)
            4:       return v[3:0];
            2:       return {2'b00, v[1:0]};
            default: return {2'b00, v[0], 1'b0};
        endcase
    endfunction

    // Mode-0 flash slave: drives on SCK fall (and CSN fall), MOSI/OEN observed on SCK rise.
    int unsigned srise, oen_bad;
    logic [7:0]  cmd_cap;
    always @(spi_sck or spi_csn) begin
        if (spi_csn !== 1'b0) begin
            srise   = 0;
            spi_sdi = 4'h0;
        end else if (spi_sck) begin
            if (srise < 8) cmd_cap = {cmd_cap[6:0], spi_sdo[0]};
            if (spi_oen !== exp_oen(srise)) oen_bad++;
            srise++;
        end else begin
            spi_sdi = slave_bits(srise);
        end
    end

    // Timing monitor and scoreboard consumer, sampled on the inactive clock edge.
    int unsigned cyc, csn_fall_c, last_edge_c, last_fall_c, first_gap, tail_gap, half_bad;
    int unsigned rises, vld_cnt, done_cnt, txn_cnt;
    logic p_csn = 1'b1, p_sck = 1'b0, have_edge = 1'b0;
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (spi_csn !== p_csn) begin
            if (spi_csn === 1'b0) begin
                csn_fall_c = cyc;
                have_edge  = 1'b0;
                rises      = 0;
                half_bad   = 0;
                txn_cnt++;
            end else begin
                tail_gap = cyc - last_fall_c;
            end
            p_csn = spi_csn;
        end
        if (spi_sck !== p_sck) begin
            if (have_edge) begin
                if (cyc - last_edge_c != 4) half_bad++;
            end else begin
                first_gap = cyc - csn_fall_c;
            end
            if (spi_sck) rises++;
            else last_fall_c = cyc;
            have_edge   = 1'b1;
            last_edge_c = cyc;
            p_sck       = spi_sck;
        end
        if (done) done_cnt++;
        if (rdata_vld) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdata_extra: got byte 0x%0h with no byte expected", rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", {24'h0, rdata}, {24'h0, e});
            end
        end
    end

    task automatic cfg(input logic [1:0] im, input logic [1:0] fm, input logic me,
                       input logic [3:0] dn, input logic [7:0] len);
        s_imode = im;
        s_fmode = fm;
        s_cmd   = spb(im);
        s_pre   = s_cmd + 3 * spb(fm) + (me ? spb(fm) : 0);
        s_ds    = s_pre + dn * spb(fm);
        s_dscks = len * spb(fm);
        imode   = im;
        fmode   = fm;
        mode_en = me;
        dummy_n = dn;
        rd_len  = len;
    endtask

    task automatic start(input string nm, input logic [7:0] c, input logic [23:0] a);
        @(negedge clk);
        cmd  = c;
        addr = a;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk({nm, "_busy_rise"}, {31'h0, busy}, 32'h1);
        chk({nm, "_csn_low"}, {31'h0, spi_csn}, 32'h0);
    endtask

    task automatic run_txn(input string nm, input logic [7:0] c, input logic [23:0] a,
                           input logic [1:0] im, input logic [1:0] fm, input logic me,
                           input logic [3:0] dn, input logic [7:0] len,
                           input int unsigned exp_rises);
        int unsigned v0, d0, o0, n;
        cfg(im, fm, me, dn, len);
        for (int i = 0; i < int'(len); i++) exp_q.push_back(flash[i]);
        v0 = vld_cnt;
        d0 = done_cnt;
        o0 = oen_bad;
        start(nm, c, a);
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done after %0d cycles", nm, n);
        end
        chk({nm, "_busy_fall"}, {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk({nm, "_rises"}, rises, exp_rises);
        chk({nm, "_vld_cnt"}, vld_cnt - v0, {24'h0, len});
        chk({nm, "_queue"}, exp_q.size(), 0);
        chk({nm, "_done_cnt"}, done_cnt - d0, 1);
        chk({nm, "_csn_to_sck"}, first_gap, 8);
        chk({nm, "_sck_to_csn"}, tail_gap, 4);
        chk({nm, "_half_period"}, half_bad, 0);
        chk({nm, "_oen"}, oen_bad - o0, 0);
        if (im != 2'b10 && im != 2'b01) chk({nm, "_cmd_bits"}, {24'h0, cmd_cap}, {24'h0, c});
    endtask

    initial begin
        int unsigned v0, d0, t0, n, dn;
        logic [7:0] init_bytes [12] = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01,
                                        8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) flash[i] = init_bytes[i];

        repeat (3) @(negedge clk);
        chk("rst_csn", {31'h0, spi_csn}, 32'h1);
        chk("rst_sck", {31'h0, spi_sck}, 32'h0);
        chk("rst_sdo", {28'h0, spi_sdo}, 32'h0);
        chk("rst_oen", {28'h0, spi_oen}, 32'hF);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_vld", {31'h0, rdata_vld}, 32'h0);
        chk("rst_rdata", {24'h0, rdata}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("quad_io", 8'hEB, 24'h000200, 2'b00, 2'b10, 1'b1, 4'd2, 8'd12, 44);
        run_txn("fast_single", 8'h0B, 24'h000200, 2'b00, 2'b00, 1'b0, 4'd1, 8'd12, 136);
        run_txn("dual_nodata", 8'h3B, 24'h123456, 2'b11, 2'b01, 1'b0, 4'd0, 8'd0, 20);

        // Reset during the fifth data byte.
        cfg(2'b00, 2'b10, 1'b1, 4'd2, 8'd12);
        for (int i = 0; i < 12; i++) exp_q.push_back(flash[i]);
        v0 = vld_cnt;
        d0 = done_cnt;
        start("rst_mid", 8'hEB, 24'h000200);
        n = 0;
        while (vld_cnt - v0 < 4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL rst_mid_timeout: only %0d bytes after %0d cycles", vld_cnt - v0, n);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_csn", {31'h0, spi_csn}, 32'h1);
        chk("rst_mid_sck", {31'h0, spi_sck}, 32'h0);
        chk("rst_mid_oen", {28'h0, spi_oen}, 32'hF);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_vld", {31'h0, rdata_vld}, 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("rst_mid_vld_cnt", vld_cnt - v0, 4);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("post_rst", 8'hEB, 24'h000200, 2'b10, 2'b10, 1'b0, 4'd1, 8'd4, 18);

        // req held high: one transaction per IDLE visit, exactly two before release.
        cfg(2'b00, 2'b10, 1'b0, 4'd0, 8'd2);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(flash[0]);
            exp_q.push_back(flash[1]);
        end
        v0 = vld_cnt;
        d0 = done_cnt;
        t0 = txn_cnt;
        @(negedge clk);
        cmd  = 8'hEB;
        addr = 24'h000200;
        req  = 1'b1;
        n    = 0;
        dn   = 0;
        while (dn < 2 && n < 4000) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                dn++;
                chk("held_busy_at_done", {31'h0, busy}, 32'h0);
                if (dn == 2) req = 1'b0;
            end
        end
        req = 1'b0;
        if (n >= 4000) begin
            checks++;
            failures++;
            $display("FAIL held_timeout: %0d done pulses after %0d cycles", dn, n);
        end
        repeat (20) @(negedge clk);
        chk("held_txn_cnt", txn_cnt - t0, 2);
        chk("held_done_cnt", done_cnt - d0, 2);
        chk("held_vld_cnt", vld_cnt - v0, 4);
        chk("held_queue", exp_q.size(), 0);
        chk("held_busy_idle", {31'h0, busy}, 32'h0);
        chk("held_rises", rises, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
